// File: rtl/bp_resolve.sv
// bp_resolve: back-end resolution of fetch-stage branch predictions.
// Holds per-branch prediction metadata in program order. Each execute-stage
// resolve pops the oldest entry and compares it against the actual outcome.
// It then drives the predictor training port and, on a mispredict, a one-cycle
// front-end redirect that also flushes all younger metadata.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   enq_*             fetch-side push of one predicted control-transfer insn
//   enq_ready         !full && !redirect_valid
//   res_*             execute-side resolve of the oldest outstanding entry
//   pc_update/valid/taken        registered predictor training strobe
//   redirect_valid/redirect_pc   registered front-end redirect
//   count             FIFO occupancy
//   resolve_err       sticky: resolve seen while FIFO empty
//   n_branch/n_mispred           wrapping statistics counters
module bp_resolve #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [PC_W-1:0]          enq_pc,
  input  logic                     enq_is_br,
  input  logic                     enq_is_call,
  input  logic                     enq_is_ret,
  input  logic                     enq_pred_taken,
  input  logic [PC_W-1:0]          enq_pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [PC_W-1:0]          res_target,
  input  logic [PC_W-1:0]          res_fallthru,
  output logic [PC_W-1:0]          pc_update,
  output logic                     valid,
  output logic                     taken,
  output logic                     redirect_valid,
  output logic [PC_W-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     resolve_err,
  output logic [CNT_W-1:0]         n_branch,
  output logic [CNT_W-1:0]         n_mispred
);
  localparam int AW = $clog2(DEPTH);

  // call and ret share one flag: both must resolve taken or they mispredict
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] target;
    logic            is_br;
    logic            is_cr;
    logic            pred_taken;
  } entry_t;

  entry_t      mem [DEPTH];
  entry_t      hd;
  logic [AW:0] head, tail;
  logic        full, empty, pop, push, mis;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign enq_ready = !full && !redirect_valid;
  assign hd        = mem[head[AW-1:0]];
  assign pop       = res_valid && !empty;

  // direction mismatch, wrong target on a correctly predicted taken,
  // or a call/ret that did not transfer control
  assign mis = pop && ((res_taken != hd.pred_taken) ||
                       (res_taken && hd.pred_taken && (res_target != hd.target)) ||
                       (hd.is_cr && !res_taken));

  // a push in the mispredict cycle is wrong-path and gets discarded
  assign push = enq_valid && enq_ready && !mis;

  always_ff @(posedge clk) begin
    if (push)
      mem[tail[AW-1:0]] <= '{pc: enq_pc, target: enq_pred_target, is_br: enq_is_br,
                             is_cr: enq_is_call | enq_is_ret, pred_taken: enq_pred_taken};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      valid          <= 1'b0;
      taken          <= 1'b0;
      pc_update      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      resolve_err    <= 1'b0;
      n_branch       <= '0;
      n_mispred      <= '0;
    end else begin
      valid          <= pop && hd.is_br;
      redirect_valid <= mis;
      if (pop && hd.is_br) begin
        pc_update <= hd.pc;
        taken     <= res_taken;
      end
      if (mis) redirect_pc <= res_taken ? res_target : res_fallthru;
      if (res_valid && empty) resolve_err <= 1'b1;
      if (pop) n_branch  <= n_branch + CNT_W'(1);
      if (mis) n_mispred <= n_mispred + CNT_W'(1);

      if (mis) begin
        // flush everything younger than the mispredicted entry
        head  <= tail;
        count <= '0;
      end else begin
        if (push) tail <= tail + (AW+1)'(1);
        if (pop)  head <= head + (AW+1)'(1);
        case ({push, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bp_resolve.sv
// Self-checking bench for bp_resolve: vector table of single-entry resolves
// plus hand-written FIFO/flush/reset sequences; training and redirect strobes
// are matched against a cycle-stamped expectation scoreboard.
module tb_bp_resolve;
  logic        clk = 1'b0;
  logic        reset;
  logic        enq_valid, enq_ready;
  logic [63:0] enq_pc, enq_pred_target;
  logic        enq_is_br, enq_is_call, enq_is_ret, enq_pred_taken;
  logic        res_valid, res_taken;
  logic [63:0] res_target, res_fallthru;
  logic [63:0] pc_update, redirect_pc;
  logic        valid, taken, redirect_valid, resolve_err;
  logic [3:0]  count;
  logic [31:0] n_branch, n_mispred;

  bp_resolve #(.DEPTH(8), .PC_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pc(enq_pc),
    .enq_is_br(enq_is_br), .enq_is_call(enq_is_call), .enq_is_ret(enq_is_ret),
    .enq_pred_taken(enq_pred_taken), .enq_pred_target(enq_pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .res_fallthru(res_fallthru),
    .pc_update(pc_update), .valid(valid), .taken(taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count), .resolve_err(resolve_err),
    .n_branch(n_branch), .n_mispred(n_mispred)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] tgt;
    logic        br, call, ret, pt;
  } ent_t;

  // kind: 0 jump, 1 br, 2 call, 3 ret
  typedef struct {
    logic [63:0] pc;
    logic [1:0]  kind;
    logic        pt;
    logic [63:0] ptg;
    logic        rt;
    logic [63:0] rtg, rft;
    logic        mis;
    logic [63:0] rpc;
    logic        trn;
  } vec_t;

  typedef struct {
    int          c;
    logic [63:0] pc;
    logic        tk;
  } exp_t;

  exp_t tq[$];
  exp_t rq[$];
  exp_t me;
  int   checks = 0, failures = 0;
  int   cyc_n = 0;
  bit   mon_en = 0;
  int   nb = 0, nm = 0;
  vec_t tbl[9];

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string nm_s, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm_s, a, e, cyc_n);
    end
  endtask

  function automatic ent_t mk(input logic [63:0] pc, input logic [1:0] k,
                              input logic pt, input logic [63:0] tg);
    ent_t e;
    e.pc = pc; e.tgt = tg; e.pt = pt;
    e.br = (k == 2'd1); e.call = (k == 2'd2); e.ret = (k == 2'd3);
    return e;
  endfunction

  // expectations land one edge after the cycle they are registered in
  task automatic exp_train(input logic [63:0] pc, input logic tk);
    tq.push_back('{cyc_n + 1, pc, tk});
  endtask

  task automatic exp_redir(input logic [63:0] pc);
    rq.push_back('{cyc_n + 1, pc, 1'b0});
  endtask

  task automatic cyc(input logic ev, input ent_t e, input logic rv, input logic rt,
                     input logic [63:0] rtg, input logic [63:0] rft);
    enq_valid = ev; enq_pc = e.pc; enq_pred_target = e.tgt;
    enq_is_br = e.br; enq_is_call = e.call; enq_is_ret = e.ret; enq_pred_taken = e.pt;
    res_valid = rv; res_taken = rt; res_target = rtg; res_fallthru = rft;
    @(posedge clk); #1;
    enq_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // scoreboard: every cycle, strobes must match exactly the expectations due now
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      chk("valid", valid, tq.size() > 0 && tq[0].c == cyc_n);
      if (tq.size() > 0 && tq[0].c == cyc_n) begin
        me = tq.pop_front();
        chk("pc_update", pc_update, me.pc);
        chk("taken", taken, me.tk);
      end
      chk("redirect_valid", redirect_valid, rq.size() > 0 && rq[0].c == cyc_n);
      if (rq.size() > 0 && rq[0].c == cyc_n) begin
        me = rq.pop_front();
        chk("redirect_pc", redirect_pc, me.pc);
      end
    end
  end

  initial begin
    //            pc      kind pt  ptg     rt  rtg     rft     mis rpc     trn
    tbl[0] = '{64'h200, 2'd1, 1, 64'h300, 1, 64'h340, 64'h204, 1, 64'h340, 1};
    tbl[1] = '{64'h210, 2'd1, 0, 64'h0,   1, 64'h380, 64'h214, 1, 64'h380, 1};
    tbl[2] = '{64'h220, 2'd1, 1, 64'h390, 0, 64'h0,   64'h224, 1, 64'h224, 1};
    tbl[3] = '{64'h230, 2'd1, 1, 64'h3a0, 1, 64'h3a0, 64'h234, 0, 64'h0,   1};
    tbl[4] = '{64'h240, 2'd3, 1, 64'h500, 1, 64'h500, 64'h244, 0, 64'h0,   0};
    tbl[5] = '{64'h600, 2'd2, 1, 64'h700, 0, 64'h0,   64'h604, 1, 64'h604, 0};
    tbl[6] = '{64'h250, 2'd0, 1, 64'h800, 1, 64'h800, 64'h254, 0, 64'h0,   0};
    tbl[7] = '{64'h260, 2'd0, 1, 64'h800, 1, 64'h880, 64'h264, 1, 64'h880, 0};
    tbl[8] = '{64'h270, 2'd3, 1, 64'h500, 1, 64'h540, 64'h274, 1, 64'h540, 0};

    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_valid", valid, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_resolve_err", resolve_err, 0);
    chk("rst_pc_update", pc_update, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_n_branch", n_branch, 0);
    chk("rst_n_mispred", n_mispred, 0);
    mon_en = 1;

    // three correctly predicted not-taken branches, resolved in order
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(64'h100 + 64'(4*i), 2'd1, 1'b0, '0), 1'b0, 1'b0, '0, '0);
    chk("seq_count3", count, 3);
    for (int i = 0; i < 3; i++) begin
      exp_train(64'h100 + 64'(4*i), 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 64'h104 + 64'(4*i));
    end
    nb += 3;
    chk("seq_count0", count, 0);
    chk("seq_n_branch", n_branch, nb);
    chk("seq_n_mispred", n_mispred, nm);

    // vector table: single-entry push then resolve
    foreach (tbl[i]) begin
      cyc(1'b1, mk(tbl[i].pc, tbl[i].kind, tbl[i].pt, tbl[i].ptg), 1'b0, 1'b0, '0, '0);
      chk("tbl_count1", count, 1);
      if (tbl[i].trn) exp_train(tbl[i].pc, tbl[i].rt);
      if (tbl[i].mis) exp_redir(tbl[i].rpc);
      cyc(1'b0, '0, 1'b1, tbl[i].rt, tbl[i].rtg, tbl[i].rft);
      nb++;
      if (tbl[i].mis) nm++;
      chk("tbl_enq_ready", enq_ready, !tbl[i].mis);
      chk("tbl_count0", count, 0);
      chk("tbl_n_branch", n_branch, nb);
      chk("tbl_n_mispred", n_mispred, nm);
      idle();
    end

    // fill to DEPTH, overflow push dropped, push+pop keeps count, order kept
    for (int i = 0; i < 8; i++) cyc(1'b1, mk(64'h1000 + 64'(4*i), 2'd1, 1'b0, '0), 1'b0, 1'b0, '0, '0);
    chk("full_count", count, 8);
    chk("full_enq_ready", enq_ready, 0);
    cyc(1'b1, mk(64'h2000, 2'd1, 1'b0, '0), 1'b0, 1'b0, '0, '0);
    chk("full_drop_count", count, 8);
    exp_train(64'h1000, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 64'h1004);
    chk("pop_count7", count, 7);
    exp_train(64'h1004, 1'b0);
    cyc(1'b1, mk(64'h1020, 2'd1, 1'b0, '0), 1'b1, 1'b0, '0, 64'h1008);
    chk("pushpop_count7", count, 7);
    for (int i = 2; i < 9; i++) begin
      exp_train(64'h1000 + 64'(4*i), 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 64'h1004 + 64'(4*i));
    end
    nb += 9;
    chk("drain_count", count, 0);
    chk("drain_n_branch", n_branch, nb);

    // mispredict at head flushes 4 younger entries and a concurrent push
    cyc(1'b1, mk(64'h3000, 2'd1, 1'b1, 64'h3100), 1'b0, 1'b0, '0, '0);
    for (int i = 1; i < 5; i++) cyc(1'b1, mk(64'h3000 + 64'(4*i), 2'd1, 1'b0, '0), 1'b0, 1'b0, '0, '0);
    chk("flush_pre_count", count, 5);
    exp_train(64'h3000, 1'b0);
    exp_redir(64'h3004);
    cyc(1'b1, mk(64'h3800, 2'd1, 1'b0, '0), 1'b1, 1'b0, '0, 64'h3004);
    nb++; nm++;
    chk("flush_count", count, 0);
    chk("flush_enq_ready", enq_ready, 0);
    cyc(1'b1, mk(64'h3900, 2'd1, 1'b0, '0), 1'b0, 1'b0, '0, '0);
    chk("redir_drop_count", count, 0);
    chk("post_redir_enq_ready", enq_ready, 1);
    cyc(1'b1, mk(64'h3a00, 2'd1, 1'b0, '0), 1'b0, 1'b0, '0, '0);
    chk("post_flush_count", count, 1);
    exp_train(64'h3a00, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 64'h3a04);
    nb++;
    chk("post_flush_n_branch", n_branch, nb);
    chk("post_flush_n_mispred", n_mispred, nm);

    // resolve on empty FIFO: sticky error, nothing else changes
    cyc(1'b0, '0, 1'b1, 1'b1, 64'h4000, 64'h4004);
    chk("err_set", resolve_err, 1);
    chk("err_n_branch", n_branch, nb);
    chk("err_count", count, 0);
    idle(); idle();
    chk("err_sticky", resolve_err, 1);
    reset = 1'b1; idle(); reset = 1'b0;
    nb = 0; nm = 0;
    chk("err_reset", resolve_err, 0);

    // reset coinciding with a mispredicting resolve aborts the redirect
    cyc(1'b1, mk(64'h600, 2'd2, 1'b1, 64'h700), 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 64'h604);
    reset = 1'b0;
    chk("abort_redirect_valid", redirect_valid, 0);
    chk("abort_n_mispred", n_mispred, 0);
    chk("abort_count", count, 0);

    // reset asserted during the redirect cycle
    cyc(1'b1, mk(64'h880, 2'd1, 1'b1, 64'h900), 1'b0, 1'b0, '0, '0);
    exp_train(64'h880, 1'b0);
    exp_redir(64'h884);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 64'h884);
    chk("redir_cycle_valid", redirect_valid, 1);
    reset = 1'b1; idle(); reset = 1'b0;
    chk("redir_rst_valid", redirect_valid, 0);
    chk("redir_rst_pc", redirect_pc, 0);
    chk("redir_rst_pc_update", pc_update, 0);
    chk("redir_rst_n_branch", n_branch, 0);
    idle(); idle();

    chk("train_queue_drained", tq.size(), 0);
    chk("redir_queue_drained", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
